// File: rtl/vec_issue_ctrl.sv
// Vector instruction issue controller: accepts one instruction, classifies it,
// drives decode selects, dispatches to CSR/execute/LSU and writes back vl.
module vec_issue_ctrl #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            inst_valid,
  output logic            inst_ready,
  input  logic [XLEN-1:0] vec_inst,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] inst_q,
  output logic [XLEN-1:0] rs1_q,
  output logic [XLEN-1:0] rs2_q,
  output logic            vl_sel,
  output logic            vtype_sel,
  output logic            lumop_sel,
  output logic            csr_wr_en,
  input  logic [XLEN-1:0] csr_vl,
  output logic            exe_start,
  input  logic            exe_done,
  output logic            lsu_start,
  input  logic            lsu_done,
  output logic            rd_wr_en,
  output logic [4:0]      rd_addr,
  output logic [XLEN-1:0] rd_data,
  output logic            inst_illegal,
  output logic            vec_busy
);

  localparam logic [6:0] OP_VEC   = 7'h57;
  localparam logic [6:0] OP_LOAD  = 7'h07;
  localparam logic [6:0] OP_STORE = 7'h27;
  localparam logic [2:0] F3_CONF  = 3'b111;

  typedef enum logic [2:0] {IDLE, DISPATCH, CONF_WB, EXE_WAIT, MEM_WAIT} state_t;
  typedef enum logic [1:0] {CLS_ILL, CLS_CONF, CLS_ARITH, CLS_MEM} cls_t;

  state_t state, state_d;
  cls_t   cls_q, in_cls;
  logic   in_vl_sel, in_vtype_sel, in_lumop_sel;
  logic   accept;

  logic   inst_ready_d, vec_busy_d;
  logic   csr_wr_en_d, exe_start_d, lsu_start_d, inst_illegal_d, rd_wr_en_d;
  logic   vl_sel_d, vtype_sel_d, lumop_sel_d;

  // Classify the incoming instruction so selects and strobes are ready at DISPATCH.
  always_comb begin
    in_cls       = CLS_ILL;
    in_vl_sel    = 1'b0;
    in_vtype_sel = 1'b0;
    in_lumop_sel = 1'b0;
    if (vec_inst[6:0] == OP_VEC) begin
      if (vec_inst[14:12] == F3_CONF) begin
        in_cls = CLS_CONF;
        if (!vec_inst[31]) begin
          in_vtype_sel = 1'b1;
        end else if (vec_inst[30]) begin
          in_vl_sel    = 1'b1;
          in_vtype_sel = 1'b1;
        end
      end else begin
        in_cls = CLS_ARITH;
      end
    end else if (vec_inst[6:0] == OP_LOAD || vec_inst[6:0] == OP_STORE) begin
      in_cls       = CLS_MEM;
      in_lumop_sel = (vec_inst[27:26] == 2'b00);
    end
  end

  always_comb begin
    state_d        = state;
    accept         = 1'b0;
    rd_wr_en_d     = 1'b0;
    case (state)
      IDLE: begin
        if (inst_valid) begin
          accept  = 1'b1;
          state_d = DISPATCH;
        end
      end
      DISPATCH: begin
        case (cls_q)
          CLS_CONF: begin
            state_d    = CONF_WB;
            rd_wr_en_d = (inst_q[11:7] != 5'd0);
          end
          CLS_ARITH: state_d = EXE_WAIT;
          CLS_MEM:   state_d = MEM_WAIT;
          default:   state_d = IDLE;
        endcase
      end
      CONF_WB:  state_d = IDLE;
      EXE_WAIT: if (exe_done) state_d = IDLE;
      MEM_WAIT: if (lsu_done) state_d = IDLE;
      default:  state_d = IDLE;
    endcase

    inst_ready_d   = (state_d == IDLE);
    vec_busy_d     = (state_d != IDLE);
    csr_wr_en_d    = accept && (in_cls == CLS_CONF);
    exe_start_d    = accept && (in_cls == CLS_ARITH);
    lsu_start_d    = accept && (in_cls == CLS_MEM);
    inst_illegal_d = accept && (in_cls == CLS_ILL);

    // Selects load on accept, hold through the operation, clear on return to IDLE.
    vl_sel_d    = vl_sel;
    vtype_sel_d = vtype_sel;
    lumop_sel_d = lumop_sel;
    if (accept) begin
      vl_sel_d    = in_vl_sel;
      vtype_sel_d = in_vtype_sel;
      lumop_sel_d = in_lumop_sel;
    end else if (state_d == IDLE) begin
      vl_sel_d    = 1'b0;
      vtype_sel_d = 1'b0;
      lumop_sel_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cls_q        <= CLS_ILL;
      inst_q       <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      inst_ready   <= 1'b1;
      vec_busy     <= 1'b0;
      csr_wr_en    <= 1'b0;
      exe_start    <= 1'b0;
      lsu_start    <= 1'b0;
      inst_illegal <= 1'b0;
      rd_wr_en     <= 1'b0;
      vl_sel       <= 1'b0;
      vtype_sel    <= 1'b0;
      lumop_sel    <= 1'b0;
    end else begin
      state        <= state_d;
      if (accept) begin
        cls_q  <= in_cls;
        inst_q <= vec_inst;
        rs1_q  <= rs1_data;
        rs2_q  <= rs2_data;
      end
      inst_ready   <= inst_ready_d;
      vec_busy     <= vec_busy_d;
      csr_wr_en    <= csr_wr_en_d;
      exe_start    <= exe_start_d;
      lsu_start    <= lsu_start_d;
      inst_illegal <= inst_illegal_d;
      rd_wr_en     <= rd_wr_en_d;
      vl_sel       <= vl_sel_d;
      vtype_sel    <= vtype_sel_d;
      lumop_sel    <= lumop_sel_d;
    end
  end

  assign rd_addr = inst_q[11:7];
  // New vl passes straight from the CSR unit during write-back.
  assign rd_data = (state == CONF_WB) ? csr_vl : '0;

endmodule

// File: tb/tb_vec_issue_ctrl.sv
// Directed bench for vec_issue_ctrl: configuration, arithmetic, memory,
// illegal and reset scenarios with hand-computed expectations.
module tb_vec_issue_ctrl;
  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] vec_inst, rs1_data, rs2_data;
  logic [XLEN-1:0] inst_q, rs1_q, rs2_q;
  logic            vl_sel, vtype_sel, lumop_sel;
  logic            csr_wr_en;
  logic [XLEN-1:0] csr_vl;
  logic            exe_start, exe_done, lsu_start, lsu_done;
  logic            rd_wr_en;
  logic [4:0]      rd_addr;
  logic [XLEN-1:0] rd_data;
  logic            inst_illegal, vec_busy;

  int vectors = 0;
  int miscompares = 0;

  // strb = {csr_wr_en, exe_start, lsu_start, inst_illegal, rd_wr_en}
  // sel  = {vl_sel, vtype_sel, lumop_sel};  hs = {inst_ready, vec_busy}
  logic [4:0] strb;
  logic [2:0] sel;
  logic [1:0] hs;
  assign strb = {csr_wr_en, exe_start, lsu_start, inst_illegal, rd_wr_en};
  assign sel  = {vl_sel, vtype_sel, lumop_sel};
  assign hs   = {inst_ready, vec_busy};

  vec_issue_ctrl #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .vec_inst(vec_inst), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .inst_q(inst_q), .rs1_q(rs1_q), .rs2_q(rs2_q),
    .vl_sel(vl_sel), .vtype_sel(vtype_sel), .lumop_sel(lumop_sel),
    .csr_wr_en(csr_wr_en), .csr_vl(csr_vl),
    .exe_start(exe_start), .exe_done(exe_done),
    .lsu_start(lsu_start), .lsu_done(lsu_done),
    .rd_wr_en(rd_wr_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .inst_illegal(inst_illegal), .vec_busy(vec_busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction for a single accepted cycle; returns in DISPATCH.
  task automatic issue(input logic [XLEN-1:0] inst, input logic [XLEN-1:0] r1,
                       input logic [XLEN-1:0] r2);
    int budget = 20;
    while (!inst_ready && budget > 0) begin
      tick();
      budget--;
    end
    vectors++;
    if (!inst_ready) begin
      miscompares++;
      $display("FAIL issue_ready_timeout inst=%h got ready=%b want 1", inst, inst_ready);
    end
    inst_valid = 1'b1; vec_inst = inst; rs1_data = r1; rs2_data = r2;
    tick();
    inst_valid = 1'b0; vec_inst = '0; rs1_data = '0; rs2_data = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    vectors++; if (hs !== 2'b10) begin miscompares++; $display("FAIL reset_hs got %b want 10", hs); end
    vectors++; if ({strb, sel} !== 8'h00) begin miscompares++; $display("FAIL reset_strb_sel got %b want 00000000", {strb, sel}); end
    vectors++; if ({inst_q, rs1_q, rs2_q} !== '0) begin miscompares++; $display("FAIL reset_regs got %h %h %h want 0", inst_q, rs1_q, rs2_q); end
    vectors++; if ({rd_addr, rd_data} !== '0) begin miscompares++; $display("FAIL reset_rd got %h %h want 0", rd_addr, rd_data); end
    reset = 1'b0;
  endtask

  task automatic test_vsetvli();
    csr_vl = 32'd8;
    issue(32'h0D0072D7, 32'd16, 32'h0000_00AA);
    vectors++; if (strb !== 5'b10000) begin miscompares++; $display("FAIL vsetvli_t1_strb got %b want 10000", strb); end
    vectors++; if (sel !== 3'b010) begin miscompares++; $display("FAIL vsetvli_sel got %b want 010", sel); end
    vectors++; if (hs !== 2'b01) begin miscompares++; $display("FAIL vsetvli_t1_hs got %b want 01", hs); end
    vectors++; if ({inst_q, rs1_q, rs2_q} !== {32'h0D0072D7, 32'd16, 32'h0000_00AA}) begin
      miscompares++; $display("FAIL vsetvli_latch got %h %h %h want 0d0072d7 00000010 000000aa", inst_q, rs1_q, rs2_q); end
    tick();
    vectors++; if (strb !== 5'b00001) begin miscompares++; $display("FAIL vsetvli_t2_strb got %b want 00001", strb); end
    vectors++; if (rd_addr !== 5'd5 || rd_data !== 32'd8) begin miscompares++; $display("FAIL vsetvli_wb got rd=%0d data=%0d want rd=5 data=8", rd_addr, rd_data); end
    vectors++; if (sel !== 3'b010) begin miscompares++; $display("FAIL vsetvli_sel_hold got %b want 010", sel); end
    tick();
    vectors++; if (hs !== 2'b10 || strb !== 5'b00000) begin miscompares++; $display("FAIL vsetvli_t3 got hs=%b strb=%b want 10 00000", hs, strb); end
  endtask

  task automatic test_vsetivli_x0();
    csr_vl = 32'd3;
    issue(32'hC0007057, 32'd0, 32'd0);
    vectors++; if (strb !== 5'b10000 || sel !== 3'b110) begin miscompares++; $display("FAIL vsetivli got strb=%b sel=%b want 10000 110", strb, sel); end
    tick();
    vectors++; if (strb !== 5'b00000 || rd_addr !== 5'd0) begin miscompares++; $display("FAIL vsetivli_x0_wb got strb=%b rd=%0d want 00000 0", strb, rd_addr); end
    tick();
    vectors++; if (hs !== 2'b10) begin miscompares++; $display("FAIL vsetivli_idle got %b want 10", hs); end
    issue(32'h80007057, 32'd4, 32'd9);
    vectors++; if (strb !== 5'b10000 || sel !== 3'b000) begin miscompares++; $display("FAIL vsetvl got strb=%b sel=%b want 10000 000", strb, sel); end
    tick(); tick();
  endtask

  task automatic test_back_to_back();
    issue(32'h02000057, 32'd1, 32'd2);
    vectors++; if (sel !== 3'b000) begin miscompares++; $display("FAIL vadd_sel got %b want 000", sel); end
    inst_valid = 1'b1; vec_inst = 32'h00000033;
    for (int i = 0; i < 6; i++) begin
      vectors++; if (hs !== 2'b01) begin miscompares++; $display("FAIL vadd_busy_c%0d got %b want 01", i, hs); end
      vectors++; if (strb !== ((i == 0) ? 5'b01000 : 5'b00000)) begin miscompares++; $display("FAIL vadd_strb_c%0d got %b", i, strb); end
      if (i == 5) exe_done = 1'b1;
      tick();
    end
    exe_done = 1'b0;
    vectors++; if (hs !== 2'b10) begin miscompares++; $display("FAIL vadd_done_idle got %b want 10", hs); end
    vectors++; if (inst_q !== 32'h02000057) begin miscompares++; $display("FAIL vadd_held got %h want 02000057", inst_q); end
    tick();
    inst_valid = 1'b0; vec_inst = '0;
    vectors++; if (inst_q !== 32'h00000033 || strb !== 5'b00010) begin miscompares++; $display("FAIL b2b_accept got inst=%h strb=%b want 00000033 00010", inst_q, strb); end
    tick();
    vectors++; if (hs !== 2'b10) begin miscompares++; $display("FAIL b2b_idle got %b want 10", hs); end
  endtask

  task automatic test_mem();
    issue(32'h00006007, 32'h1000, 32'd0);
    vectors++; if (strb !== 5'b00100 || sel !== 3'b001) begin miscompares++; $display("FAIL vle32 got strb=%b sel=%b want 00100 001", strb, sel); end
    tick();
    vectors++; if (strb !== 5'b00000 || hs !== 2'b01 || sel !== 3'b001) begin miscompares++; $display("FAIL vle32_wait got strb=%b hs=%b sel=%b", strb, hs, sel); end
    lsu_done = 1'b1; tick(); lsu_done = 1'b0;
    vectors++; if (hs !== 2'b10) begin miscompares++; $display("FAIL vle32_done got %b want 10", hs); end
    issue(32'h08006007, 32'h2000, 32'd16);
    vectors++; if (strb !== 5'b00100 || sel !== 3'b000) begin miscompares++; $display("FAIL vlse got strb=%b sel=%b want 00100 000", strb, sel); end
    tick(); tick();
    vectors++; if (hs !== 2'b01) begin miscompares++; $display("FAIL vlse_wait got %b want 01", hs); end
    lsu_done = 1'b1; tick(); lsu_done = 1'b0;
    vectors++; if (hs !== 2'b10) begin miscompares++; $display("FAIL vlse_done got %b want 10", hs); end
    issue(32'h00006027, 32'h3000, 32'd0);
    vectors++; if (strb !== 5'b00100 || sel !== 3'b001) begin miscompares++; $display("FAIL vse32 got strb=%b sel=%b want 00100 001", strb, sel); end
    lsu_done = 1'b1; tick(); tick(); lsu_done = 1'b0;
    lsu_done = 1'b1; tick(); tick(); lsu_done = 1'b0;
    vectors++; if (hs !== 2'b10 || strb !== 5'b00000) begin miscompares++; $display("FAIL stray_lsu_done got hs=%b strb=%b want 10 00000", hs, strb); end
  endtask

  task automatic test_illegal();
    issue(32'h00000033, 32'd0, 32'd0);
    vectors++; if (strb !== 5'b00010 || hs !== 2'b01) begin miscompares++; $display("FAIL illegal_t1 got strb=%b hs=%b want 00010 01", strb, hs); end
    tick();
    vectors++; if (strb !== 5'b00000 || hs !== 2'b10) begin miscompares++; $display("FAIL illegal_t2 got strb=%b hs=%b want 00000 10", strb, hs); end
  endtask

  task automatic test_reset_mid();
    issue(32'h02000057, 32'd7, 32'd8);
    tick();
    vectors++; if (hs !== 2'b01) begin miscompares++; $display("FAIL mid_exe_wait got %b want 01", hs); end
    reset = 1'b1; tick(); reset = 1'b0;
    vectors++; if (hs !== 2'b10 || {strb, sel} !== 8'h00) begin miscompares++; $display("FAIL mid_reset got hs=%b strb=%b sel=%b", hs, strb, sel); end
    vectors++; if ({inst_q, rs1_q, rs2_q} !== '0) begin miscompares++; $display("FAIL mid_reset_regs got %h %h %h want 0", inst_q, rs1_q, rs2_q); end
    exe_done = 1'b1; tick(); exe_done = 1'b0; tick();
    vectors++; if (hs !== 2'b10 || strb !== 5'b00000) begin miscompares++; $display("FAIL mid_stale_done got hs=%b strb=%b want 10 00000", hs, strb); end
  endtask

  initial begin
    reset = 1'b1; inst_valid = 1'b0; vec_inst = '0; rs1_data = '0; rs2_data = '0;
    csr_vl = '0; exe_done = 1'b0; lsu_done = 1'b0;
    test_reset();
    test_vsetvli();
    test_vsetivli_x0();
    test_back_to_back();
    test_mem();
    test_illegal();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/vec_issue_ctrl.md
# vec_issue_ctrl

Sequencing controller between the scalar core and the vector co-processor front end. It accepts one vector instruction at a time over a valid/ready handshake and holds the instruction and its scalar operands stable for `vec_decode`. It classifies the instruction, drives the decode mux selects (`vl_sel`, `vtype_sel`, `lumop_sel`) and dispatches to the CSR unit, the vector execute unit or the vector load/store unit. It waits for completion before accepting the next instruction and returns the new `vl` to the scalar register file after configuration instructions.

## Interface
Parameters:
- `XLEN`, 32, width of the instruction and scalar operands

Ports (one clock domain; reset is synchronous, active-high):
- `clk` in 1: clock
- `reset` in 1: synchronous active-high reset
- `inst_valid` in 1: scalar core presents an instruction
- `inst_ready` out 1: controller can accept an instruction
- `vec_inst` in XLEN: raw instruction
- `rs1_data` in XLEN: scalar rs1 value
- `rs2_data` in XLEN: scalar rs2 value
- `inst_q` out XLEN: latched instruction, feeds `vec_decode.vec_inst`
- `rs1_q` out XLEN: latched rs1 value
- `rs2_q` out XLEN: latched rs2 value
- `vl_sel` out 1: 1 selects uimm for scalar1
- `vtype_sel` out 1: 1 selects zimm for scalar2
- `lumop_sel` out 1: 1 selects lumop for scalar2
- `csr_wr_en` out 1: one-cycle CSR update strobe
- `csr_vl` in XLEN: vl computed by the CSR unit, valid the cycle after `csr_wr_en`
- `exe_start` out 1: one-cycle start to execute unit
- `exe_done` in 1: execute unit finished
- `lsu_start` out 1: one-cycle start to load/store unit
- `lsu_done` in 1: load/store unit finished
- `rd_wr_en` out 1: scalar rd write strobe
- `rd_addr` out 5: scalar rd index (`inst_q[11:7]`)
- `rd_data` out XLEN: value written to rd
- `inst_illegal` out 1: one-cycle pulse, instruction not a vector instruction
- `vec_busy` out 1: high whenever state is not IDLE

## Operation
- States: IDLE, DISPATCH, CONF_WB, EXE_WAIT, MEM_WAIT.
- IDLE: `inst_ready`=1. When `inst_valid` is high, latch `vec_inst`, `rs1_data` and `rs2_data` into `inst_q`, `rs1_q` and `rs2_q`, then go to DISPATCH.
- DISPATCH classifies on `inst_q[6:0]` and `inst_q[14:12]`:
  - CONF (opcode 0x57, func3 3'b111): pulse `csr_wr_en`, then go to CONF_WB.
  - ARITH (opcode 0x57, other func3): pulse `exe_start`, then go to EXE_WAIT.
  - LOAD (0x07) / STORE (0x27): pulse `lsu_start`, then go to MEM_WAIT.
  - Anything else: pulse `inst_illegal`, then go to IDLE.
- Select encoding is registered, computed on accept and held constant from DISPATCH until IDLE is re-entered:
  - VSETVLI (`inst[31]`=0): `vl_sel`=0, `vtype_sel`=1.
  - VSETIVLI (`inst[31:30]`=11): `vl_sel`=1, `vtype_sel`=1.
  - VSETVL (`inst[31:30]`=10): `vl_sel`=0, `vtype_sel`=0.
  - `lumop_sel`=1 only for LOAD/STORE with mop (`inst[27:26]`)=00 (unit-stride).
  - All selects are 0 for every other case.
- CONF_WB: `rd_data`=`csr_vl`. `rd_wr_en`=1 only if `rd_addr`≠0. Then go to IDLE.
- EXE_WAIT: stay until `exe_done`=1, then go to IDLE. MEM_WAIT is the same with `lsu_done`.
- `exe_done`/`lsu_done` are ignored in every state other than the matching WAIT state.
- `inst_q`, `rs1_q` and `rs2_q` change only on an accept.

## Timing
- All outputs are registered or decoded from state only; there are no combinational input-to-output paths except `rd_data`=`csr_vl` in CONF_WB.
- Handshake accepted at edge T: DISPATCH at T+1, start/strobe visible during T+1.
  - CONF: `rd_wr_en` at T+2, `inst_ready` at T+3. Minimum 3 cycles per instruction.
  - ARITH/MEM: done sampled at T+n puts IDLE at T+n+1. Done is allowed in the cycle right after start, giving 3 cycles minimum.
  - Illegal: IDLE at T+2.
- Start strobes and `inst_illegal` are exactly one cycle wide.
- Reset values: state IDLE, `inst_ready`=1 (the first cycle after reset), `inst_q`/`rs1_q`/`rs2_q`=0, and every other output 0.
- Reset mid-operation: the next edge returns to IDLE with no strobe. A pending done from the aborted operation is ignored.
- `inst_valid` held high while not ready is not accepted; the instruction is taken on the first IDLE cycle.

## Test plan
- Reset then VSETVLI x5 (`inst`=0x0D0072D7, rs1=16), `csr_vl`=8 -> `csr_wr_en` at T+1 with `vl_sel`=0, `vtype_sel`=1; `rd_wr_en` at T+2 with `rd_addr`=5, `rd_data`=8; `inst_ready`=1 at T+3.
- VSETIVLI with rd=x0 (`inst[31:30]`=11) -> `vl_sel`=`vtype_sel`=1, `csr_wr_en` pulses, `rd_wr_en` stays 0.
- vadd.vv (opcode 0x57, func3 000), `exe_done` raised 5 cycles after `exe_start` -> `vec_busy` high 6 cycles, `inst_ready` 0 throughout; a second `inst_valid` held high is accepted on the first IDLE cycle.
- Unit-stride vle32 (0x07, mop=00) -> `lumop_sel`=1 and `lsu_start` pulses. Strided load (mop=10) -> `lumop_sel`=0. Stray `lsu_done` while in IDLE causes no state change.
- Opcode 0x33 -> `inst_illegal` pulses one cycle at T+1, no start strobes, IDLE at T+2.
- `reset` asserted while in EXE_WAIT, then `exe_done` pulsed -> IDLE, all outputs 0 apart from `inst_ready`=1, no strobe issued.
